// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
// Default widths, the capture FSM encoding and the divider iteration count.
package pwm_capture_pkg;

   localparam int CW_DEF   = 32;
   localparam int DW_DEF   = 24;
   localparam int SYNC_DEF = 2;

   localparam logic [DW_DEF-1:0] DUTY_FULL = {DW_DEF{1'b1}};

   // One quotient bit per iteration, so the count equals the duty width.
   localparam int DIV_ITERS = DW_DEF;

   typedef enum logic [0:0] {
      ARM  = 1'b0,
      MEAS = 1'b1
   } state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Register-bus facing signal bundle of the PWM capture block.
// master = bus/housekeeping side, slave = the capture core.
interface pwm_capture_if #(
   parameter int CW = 32,
   parameter int DW = 24
);
   logic          en_i;
   logic          pwm_i;
   logic [CW-1:0] timeout_i;
   logic [CW-1:0] period_o;
   logic [CW-1:0] high_o;
   logic [DW-1:0] duty_o;
   logic          valid_o;
   logic          stuck_o;
   logic          drop_o;

   modport master (
      output en_i, pwm_i, timeout_i,
      input  period_o, high_o, duty_o, valid_o, stuck_o, drop_o
   );

   modport slave (
      input  en_i, pwm_i, timeout_i,
      output period_o, high_o, duty_o, valid_o, stuck_o, drop_o
   );
endinterface

// File: rtl/pwm_capture_div.sv
// Serial restoring divider: quo = floor((hi << DW) / per), saturated when hi >= per.
// One quotient bit per clock; operands are held so the caller can read them with the result.
module pwm_capture_div
   import pwm_capture_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int DW = DIV_ITERS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic          abort_i,
   input  logic [CW-1:0] per_i,
   input  logic [CW-1:0] hi_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [DW-1:0] quo_o,
   output logic [CW-1:0] per_o,
   output logic [CW-1:0] hi_o
);

   localparam int CNTW = $clog2(DW + 1);
   localparam int WW   = CW + DW + 1;

   logic            busy_q;
   logic            done_q;
   logic            sat_q;
   logic [CNTW-1:0] cnt_q;
   logic [WW-1:0]   work_q;
   logic [WW-1:0]   work_d;
   logic [WW-1:0]   shift_s;
   logic [CW:0]     rem_s;
   logic [CW-1:0]   per_q;
   logic [CW-1:0]   hi_q;
   logic [DW-1:0]   quo_q;

   // Upper CW+1 bits hold the partial remainder, lower DW bits collect quotient bits.
   always_comb begin
      shift_s = {work_q[WW-2:0], 1'b0};
      rem_s   = shift_s[WW-1:DW];
      if (rem_s >= {1'b0, per_q}) begin
         work_d = {rem_s - {1'b0, per_q}, shift_s[DW-1:1], 1'b1};
      end else begin
         work_d = shift_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sat_q  <= 1'b0;
         cnt_q  <= {CNTW{1'b0}};
         work_q <= {WW{1'b0}};
         per_q  <= {CW{1'b0}};
         hi_q   <= {CW{1'b0}};
         quo_q  <= {DW{1'b0}};
      end else begin
         done_q <= 1'b0;
         if (abort_i) begin
            busy_q <= 1'b0;
         end else if (start_i && !busy_q) begin
            busy_q <= 1'b1;
            cnt_q  <= CNTW'(DW);
            work_q <= {1'b0, hi_i, {DW{1'b0}}};
            per_q  <= per_i;
            hi_q   <= hi_i;
            sat_q  <= (hi_i >= per_i);
         end else if (busy_q) begin
            work_q <= work_d;
            cnt_q  <= cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               quo_q  <= sat_q ? {DW{1'b1}} : work_d[DW-1:0];
            end else begin
               quo_q  <= quo_q;
            end
         end else begin
            busy_q <= 1'b0;
         end
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign quo_o  = quo_q;
   assign per_o  = per_q;
   assign hi_o   = hi_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of an asynchronous input and
// recovers the duty cycle as a DW-bit fraction, with stuck-line timeout and overrun flag.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CW   = CW_DEF,
   parameter int DW   = DW_DEF,
   parameter int SYNC = SYNC_DEF
) (
   input  logic         clk,
   input  logic         rst,
   pwm_capture_if.slave bus
);

   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [DW-1:0] DUTY_MAX = {DW{1'b1}};

   logic [SYNC-1:0] sync_q;
   logic            s_d_q;
   logic            s_s;
   logic            rise_s;

   state_e          state_q;
   logic [CW-1:0]   per_cnt_q;
   logic [CW-1:0]   hi_cnt_q;
   logic [CW-1:0]   per_inc_s;
   logic [CW-1:0]   hi_inc_s;
   logic            pend_q;
   logic [CW-1:0]   pend_per_q;
   logic [CW-1:0]   pend_hi_q;
   logic            drop_q;
   logic            stuck_q;
   logic [CW-1:0]   period_q;
   logic [CW-1:0]   high_q;
   logic [DW-1:0]   duty_q;
   logic            valid_q;

   logic            tmo_hit_s;
   logic            div_start_s;
   logic            div_abort_s;
   logic            div_busy_s;
   logic            div_done_s;
   logic [DW-1:0]   div_quo_s;
   logic [CW-1:0]   div_per_s;
   logic [CW-1:0]   div_hi_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC{1'b0}};
         s_d_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC-2:0], bus.pwm_i};
         s_d_q  <= sync_q[SYNC-1];
      end
   end

   assign s_s       = sync_q[SYNC-1];
   assign rise_s    = s_s & ~s_d_q;
   assign per_inc_s = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
   assign hi_inc_s  = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CNT_ONE;

   // A rise always wins over a timeout hitting in the same cycle.
   always_comb begin
      tmo_hit_s   = 1'b0;
      div_start_s = 1'b0;
      div_abort_s = 1'b0;
      if (!bus.en_i) begin
         div_abort_s = 1'b1;
      end else begin
         if ((state_q == MEAS) && !rise_s && (bus.timeout_i != {CW{1'b0}}) &&
             (per_cnt_q == bus.timeout_i)) begin
            tmo_hit_s = 1'b1;
         end else begin
            tmo_hit_s = 1'b0;
         end
         div_abort_s = tmo_hit_s;
         div_start_s = pend_q & ~div_busy_s & ~tmo_hit_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ARM;
         per_cnt_q  <= {CW{1'b0}};
         hi_cnt_q   <= {CW{1'b0}};
         pend_q     <= 1'b0;
         pend_per_q <= {CW{1'b0}};
         pend_hi_q  <= {CW{1'b0}};
         drop_q     <= 1'b0;
         stuck_q    <= 1'b0;
         period_q   <= {CW{1'b0}};
         high_q     <= {CW{1'b0}};
         duty_q     <= {DW{1'b0}};
         valid_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (!bus.en_i) begin
            state_q   <= ARM;
            per_cnt_q <= {CW{1'b0}};
            hi_cnt_q  <= {CW{1'b0}};
            pend_q    <= 1'b0;
            drop_q    <= 1'b0;
            stuck_q   <= 1'b0;
         end else begin
            if (div_start_s) begin
               pend_q <= 1'b0;
            end else begin
               pend_q <= pend_q;
            end
            if (div_done_s) begin
               period_q <= div_per_s;
               high_q   <= div_hi_s;
               duty_q   <= div_quo_s;
               valid_q  <= 1'b1;
            end else begin
               valid_q  <= 1'b0;
            end
            case (state_q)
               ARM: begin
                  if (rise_s) begin
                     state_q   <= MEAS;
                     per_cnt_q <= CNT_ONE;
                     hi_cnt_q  <= CNT_ONE;
                  end else begin
                     per_cnt_q <= {CW{1'b0}};
                     hi_cnt_q  <= {CW{1'b0}};
                  end
               end
               MEAS: begin
                  if (rise_s) begin
                     pend_per_q <= per_cnt_q;
                     pend_hi_q  <= hi_cnt_q;
                     pend_q     <= 1'b1;
                     if (pend_q && !div_start_s) begin
                        drop_q <= 1'b1;
                     end else begin
                        drop_q <= drop_q;
                     end
                     per_cnt_q <= CNT_ONE;
                     hi_cnt_q  <= CNT_ONE;
                     stuck_q   <= 1'b0;
                  end else if (tmo_hit_s) begin
                     // Timeout overrides any divider result completing this cycle.
                     state_q   <= ARM;
                     stuck_q   <= 1'b1;
                     pend_q    <= 1'b0;
                     per_cnt_q <= {CW{1'b0}};
                     hi_cnt_q  <= {CW{1'b0}};
                     period_q  <= bus.timeout_i;
                     high_q    <= s_s ? bus.timeout_i : {CW{1'b0}};
                     duty_q    <= s_s ? DUTY_MAX : {DW{1'b0}};
                     valid_q   <= 1'b1;
                  end else begin
                     per_cnt_q <= per_inc_s;
                     hi_cnt_q  <= s_s ? hi_inc_s : hi_cnt_q;
                  end
               end
               default: begin
                  state_q <= ARM;
               end
            endcase
         end
      end
   end

   pwm_capture_div #(
      .CW (CW),
      .DW (DW)
   ) u_div (
      .clk     (clk),
      .rst     (rst),
      .start_i (div_start_s),
      .abort_i (div_abort_s),
      .per_i   (pend_per_q),
      .hi_i    (pend_hi_q),
      .busy_o  (div_busy_s),
      .done_o  (div_done_s),
      .quo_o   (div_quo_s),
      .per_o   (div_per_s),
      .hi_o    (div_hi_s)
   );

   assign bus.period_o = period_q;
   assign bus.high_o   = high_q;
   assign bus.duty_o   = duty_q;
   assign bus.valid_o  = valid_q;
   assign bus.stuck_o  = stuck_q;
   assign bus.drop_o   = drop_q;

endmodule
